// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 modified Booth recoding (half the iterations).
package booth_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

`ifdef BOOTH_RADIX4_EN
  localparam bit          RADIX4      = 1'b1;
  localparam int unsigned RECODE_BITS = 3;
`else
  localparam bit          RADIX4      = 1'b0;
  localparam int unsigned RECODE_BITS = 2;
`endif

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    DigZero   = 3'd0,
    DigPlus1  = 3'd1,
    DigMinus1 = 3'd2,
    DigPlus2  = 3'd3,
    DigMinus2 = 3'd4
  } digit_e;

  // Radix-4 retires two multiplier bits per step.
  function automatic int unsigned num_iter(int unsigned width, bit radix4);
    return radix4 ? width / 2 : width;
  endfunction

endpackage

// File: rtl/booth_seq_mult_core_if.sv
// Start/done multiply handshake between an initiator FSM and the Booth core.
interface booth_seq_mult_core_if #(
  parameter int unsigned WIDTH = booth_pkg::DEFAULT_WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   product;
  logic                 done;
  logic                 busy;

  modport master (
    output start, multiplicand, multiplier,
    input  product, done, busy
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, done, busy
  );
endinterface

// File: rtl/booth_digit_recoder.sv
// Maps Booth recoding bits to add/double/negate controls for one step.
// BOOTH_RADIX4_EN selects the radix-4 table; otherwise radix-2.
module booth_digit_recoder
  import booth_pkg::*;
(
  input  logic [RECODE_BITS-1:0] bits,
  output logic                   add_en,
  output logic                   sel_two,
  output logic                   negate
);

  digit_e digit;

  always_comb begin
    digit = DigZero;
`ifdef BOOTH_RADIX4_EN
    unique case (bits)
      3'b001, 3'b010: digit = DigPlus1;
      3'b011:         digit = DigPlus2;
      3'b100:         digit = DigMinus2;
      3'b101, 3'b110: digit = DigMinus1;
      default:        digit = DigZero;
    endcase
`else
    unique case (bits)
      2'b01:   digit = DigPlus1;
      2'b10:   digit = DigMinus1;
      default: digit = DigZero;
    endcase
`endif
    add_en  = (digit != DigZero);
    sel_two = (digit == DigPlus2) || (digit == DigMinus2);
    negate  = (digit == DigMinus1) || (digit == DigMinus2);
  end

endmodule

// File: rtl/booth_seq_mult_core.sv
// Sequential signed Booth multiplier; one operand pair per start, one-cycle done pulse.
// BOOTH_RADIX4_EN (via booth_pkg) halves latency using radix-4 recoding.
module booth_seq_mult_core
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  booth_seq_mult_core_if.slave  bus
);

  localparam int unsigned NUM_ITER = num_iter(WIDTH, RADIX4);
  localparam int unsigned SHIFT    = RADIX4 ? 2 : 1;
  // Extra headroom bits keep -M and -2M representable for the most negative M.
  localparam int unsigned AW       = WIDTH + SHIFT;
  localparam int unsigned CW       = AW + WIDTH + 1;
  localparam int unsigned CNT_W    = $clog2(NUM_ITER + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ITER - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      m_q, m_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic                  qm1_q, qm1_d;
  logic [2*WIDTH-1:0]    product_q, product_d;
  logic                  done_q, done_d;

  logic                  add_en, sel_two, negate;
  logic [RECODE_BITS-1:0] rec_bits;
  logic [AW-1:0]         m_ext, addend, sum;
  logic signed [CW-1:0]  shifted;

  assign rec_bits = {q_q[RECODE_BITS-2:0], qm1_q};

  booth_digit_recoder u_recoder (
    .bits    (rec_bits),
    .add_en  (add_en),
    .sel_two (sel_two),
    .negate  (negate)
  );

  assign m_ext   = {{SHIFT{m_q[WIDTH-1]}}, m_q};
  assign addend  = sel_two ? (m_ext << 1) : m_ext;
  assign sum     = add_en ? (negate ? acc_q - addend : acc_q + addend) : acc_q;
  assign shifted = $signed({sum, q_q, qm1_q}) >>> SHIFT;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    qm1_d     = qm1_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          m_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = shifted[CW-1 -: AW];
        q_d   = shifted[WIDTH:1];
        qm1_d = shifted[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          product_d = {acc_d[WIDTH-1:0], q_d};
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      qm1_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      qm1_q     <= qm1_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q == StBusy);

endmodule

// File: tb/tb_booth_seq_mult_core.sv
// Directed-vector and corner-case bench for booth_seq_mult_core (WIDTH=16).
module tb_booth_seq_mult_core;

`ifdef BOOTH_RADIX4_EN
  localparam int N = 8;
`else
  localparam int N = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  booth_seq_mult_core_if #(.WIDTH(16)) bus ();

  booth_seq_mult_core #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          a;
    int          b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one multiply and wait (bounded) for done; returns product, latency, busy flag.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] p, output int lat, output bit busy_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.multiplicand = 16'($urandom);
    bus.multiplier = 16'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    p = bus.product;
  endtask

  logic [31:0] p;
  int          lat;
  bit          busy_ok;
  int          dones;
  int          gap;
  bit          flag;
  logic [31:0] first_p;
  logic signed [15:0] ra, rb;
  logic [31:0] rexp;
  int          rand_errs;
  int          lat_errs;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3, 5, 32'd15};
    vecs[1]  = '{-7, 6, 32'hFFFF_FFD6};
    vecs[2]  = '{-32768, -32768, 32'h4000_0000};
    vecs[3]  = '{-32768, 32767, 32'hC000_8000};
    vecs[4]  = '{32767, 32767, 32'h3FFF_0001};
    vecs[5]  = '{-1, -1, 32'd1};
    vecs[6]  = '{1, -1, 32'hFFFF_FFFF};
    vecs[7]  = '{0, 1234, 32'd0};
    vecs[8]  = '{12345, -321, 32'hFFC3_8887};
    vecs[9]  = '{100, 100, 32'd10000};
    vecs[10] = '{-32768, 1, 32'hFFFF_8000};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (2) @(negedge clk);
    check("reset_product", 64'(bus.product), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(16'(vecs[i].a), 16'(vecs[i].b), p, lat, busy_ok);
      check($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].p));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(N));
      check($sformatf("vec%0d_busy_during", i), 64'(busy_ok), 64'd1);
      check($sformatf("vec%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), 64'(bus.done), 64'd0);
      check($sformatf("vec%0d_product_hold", i), 64'(bus.product), 64'(vecs[i].p));
    end

    // Start while busy: second request must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 16'd3; bus.multiplier = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 16'd100; bus.multiplier = 16'd100;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    first_p = '0;
    for (int c = 0; c < 2 * N + 10; c++) begin
      if (bus.done === 1'b1) begin
        if (dones == 0) first_p = bus.product;
        dones++;
      end
      @(negedge clk);
    end
    check("busy_start_done_count", 64'(dones), 64'd1);
    check("busy_start_product", 64'(first_p), 64'd15);

    // Back-to-back: relaunch in the done cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 16'd4; bus.multiplier = 16'd4;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_product", 64'(bus.product), 64'd16);
    bus.start = 1'b1; bus.multiplicand = 16'd2; bus.multiplier = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    gap = 1;
    flag = 1'b1;
    while (bus.done !== 1'b1 && gap < 200) begin
      if (bus.product !== 32'd16) flag = 1'b0;
      @(negedge clk);
      gap++;
    end
    check("b2b_second_product", 64'(bus.product), 64'd18);
    check("b2b_gap", 64'(gap), 64'(N + 1));
    check("b2b_hold", 64'(flag), 64'd1);

    // Reset mid-operation aborts without a done.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 16'd11; bus.multiplier = 16'd13;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_product", 64'(bus.product), 64'd0);
    check("midreset_done", 64'(bus.done), 64'd0);
    check("midreset_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b1;
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) flag = 1'b0;
    end
    check("midreset_no_done", 64'(flag), 64'd1);
    run_op(16'd11, 16'd13, p, lat, busy_ok);
    check("post_reset_product", 64'(p), 64'd143);
    check("post_reset_latency", 64'(lat), 64'(N));

    // Random signed pairs against the behavioural product.
    rand_errs = 0;
    lat_errs = 0;
    for (int k = 0; k < 2000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rexp = 32'(int'(ra) * int'(rb));
      run_op(ra, rb, p, lat, busy_ok);
      checks++;
      if (p !== rexp) begin
        errors++;
        rand_errs++;
        if (rand_errs <= 5)
          $display("FAIL rand_product %0d*%0d: got 0x%0h expected 0x%0h", ra, rb, p, rexp);
      end
      if (lat != N) lat_errs++;
    end
    check("rand_latency_errors", 64'(lat_errs), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
